pkt_scheduler: RTL and testbench

Round-robin, token-bucket-paced scheduler that drains up to NUM_QUEUES packet-descriptor FIFOs (fall-through; entry = {five-tuple, 16-bit pkt_len}, length in the low 16 bits) and issues one descriptor at a time to the packet builder over a valid/ready interface. Sits between the per-flow input queues and the packet generator. Shares the builder fairly among queues and limits the aggregate output rate to a programmed byte budget.

---
 rtl/pkt_scheduler.sv | 131 +++++++++++++
 tb/tb_pkt_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_scheduler.sv
// Purpose : round-robin, token-bucket-paced scheduler draining NUM_QUEUES descriptor FIFOs into one builder port.
// Latency : pop in IDLE at cycle N, WAIT_TOKEN at N+1, sched_vld earliest N+2; at least 3 cycles per descriptor.
// Backpres: sched_vld holds with a stable payload until sched_ready; no pop happens until the descriptor is accepted.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   fifo_data_in         flattened fall-through FIFO heads, {tuple, len[15:0]} per queue
//   fifo_empty           per-queue empty flags
//   fifo_rd_en           one-hot pop strobe, only in IDLE, never to an empty queue
//   cfg_enable           allows new arbitration (does not abort a captured descriptor)
//   cfg_rate             tokens (bytes) added every cycle
//   cfg_bucket_max       token bucket ceiling
//   sched_*              issued descriptor, valid/ready handshake
//   sched_busy           high whenever a descriptor is held
//   pkt_count            descriptors accepted since reset (wraps)
module pkt_scheduler #(
    parameter int NUM_QUEUES      = 4,
    parameter int PKT_TUPLE_WIDTH = 104,
    parameter int TOKEN_WIDTH     = 24,
    localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    localparam int EW = PKT_TUPLE_WIDTH + 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_QUEUES*EW-1:0]   fifo_data_in,
    input  logic [NUM_QUEUES-1:0]      fifo_empty,
    output logic [NUM_QUEUES-1:0]      fifo_rd_en,
    input  logic                       cfg_enable,
    input  logic [TOKEN_WIDTH-1:0]     cfg_rate,
    input  logic [TOKEN_WIDTH-1:0]     cfg_bucket_max,
    output logic [PKT_TUPLE_WIDTH-1:0] sched_tuple,
    output logic [15:0]                sched_len,
    output logic [QW-1:0]              sched_qid,
    output logic                       sched_vld,
    input  logic                       sched_ready,
    output logic                       sched_busy,
    output logic [31:0]                pkt_count
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_TOKEN = 2'd1;
    localparam logic [1:0] SEND       = 2'd2;

    logic [1:0]             state;
    logic [QW-1:0]          last_grant;
    logic [QW-1:0]          winner;
    logic [QW-1:0]          cand;
    logic                   found;
    logic                   pick;
    logic [EW-1:0]          head;
    logic [TOKEN_WIDTH-1:0] tokens;
    logic [TOKEN_WIDTH-1:0] charge;
    logic [TOKEN_WIDTH-1:0] debit;
    logic                   tok_ok;
    logic [TOKEN_WIDTH:0]   tok_sum;
    logic [TOKEN_WIDTH-1:0] tok_next;

    // Round-robin search: first non-empty queue starting just after the last granted one.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            cand = QW'((int'(last_grant) + k) % NUM_QUEUES);
            if (!found && !fifo_empty[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign pick = (state == IDLE) && cfg_enable && found;
    assign head = fifo_data_in[int'(winner)*EW +: EW];

    // The pop strobe is combinational, so it is also gated by reset to keep
    // queues untouched while the block is held in reset.
    assign fifo_rd_en = (pick && resetn) ? (NUM_QUEUES'(1) << winner) : '0;

    // Oversized packets are charged a full bucket so they can never deadlock.
    assign charge = ({{TOKEN_WIDTH{1'b0}}, sched_len} > {16'd0, cfg_bucket_max})
                    ? cfg_bucket_max : TOKEN_WIDTH'(sched_len);
    assign tok_ok = (tokens >= charge);
    assign debit  = ((state == WAIT_TOKEN) && tok_ok) ? charge : '0;

    // One extra bit of headroom: debit never exceeds tokens, and the add can
    // only exceed the ceiling, which is clamped straight back.
    assign tok_sum  = {1'b0, tokens} - {1'b0, debit} + {1'b0, cfg_rate};
    assign tok_next = (tok_sum > {1'b0, cfg_bucket_max}) ? cfg_bucket_max
                                                          : tok_sum[TOKEN_WIDTH-1:0];

    assign sched_vld  = (state == SEND);
    assign sched_busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            tokens      <= '0;
            last_grant  <= QW'(NUM_QUEUES - 1);
            sched_tuple <= '0;
            sched_len   <= '0;
            sched_qid   <= '0;
            pkt_count   <= '0;
        end else begin
            tokens <= tok_next;
            case (state)
                IDLE: begin
                    if (pick) begin
                        sched_tuple <= head[EW-1:16];
                        sched_len   <= head[15:0];
                        sched_qid   <= winner;
                        state       <= WAIT_TOKEN;
                    end
                end
                WAIT_TOKEN: begin
                    if (tok_ok) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (sched_ready) begin
                        pkt_count  <= pkt_count + 32'd1;
                        last_grant <= sched_qid;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_scheduler.sv
// Purpose : self-checking bench for pkt_scheduler with fall-through FIFO models and an in-order scoreboard.
// Latency : latencies are measured in clock edges after reset release and compared to token-bucket arithmetic.
// Backpres: sched_ready is driven per test; stalls check that the payload matches the scoreboard head.
module tb_pkt_scheduler;

    localparam int NQ    = 4;
    localparam int TW    = 104;
    localparam int KW    = 24;
    localparam int EW    = TW + 16;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [1:0]    qid;
        logic [15:0]   len;
        logic [TW-1:0] tuple;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic [NQ*EW-1:0]  fifo_data_in;
    logic [NQ-1:0]     fifo_empty;
    logic [NQ-1:0]     fifo_rd_en;
    logic              cfg_enable = 1'b1;
    logic [KW-1:0]     cfg_rate = '0;
    logic [KW-1:0]     cfg_bucket_max = '0;
    logic [TW-1:0]     sched_tuple;
    logic [15:0]       sched_len;
    logic [1:0]        sched_qid;
    logic              sched_vld;
    logic              sched_ready = 1'b1;
    logic              sched_busy;
    logic [31:0]       pkt_count;

    pkt_scheduler #(.NUM_QUEUES(NQ), .PKT_TUPLE_WIDTH(TW), .TOKEN_WIDTH(KW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .fifo_data_in   (fifo_data_in),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .cfg_enable     (cfg_enable),
        .cfg_rate       (cfg_rate),
        .cfg_bucket_max (cfg_bucket_max),
        .sched_tuple    (sched_tuple),
        .sched_len      (sched_len),
        .sched_qid      (sched_qid),
        .sched_vld      (sched_vld),
        .sched_ready    (sched_ready),
        .sched_busy     (sched_busy),
        .pkt_count      (pkt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO models: write side owned by the stimulus, read side by the pop process.
    logic [EW-1:0] mem [NQ][DEPTH];
    int            wr_ptr   [NQ] = '{default: 0};
    int            rd_ptr   [NQ] = '{default: 0};
    int            pop_cnt  [NQ] = '{default: 0};
    int            pop_base [NQ] = '{default: 0};
    logic [NQ-1:0] pend = '0;
    int            acc_cnt  = 0;
    int            acc_base = 0;
    exp_t          exp_q[$];

    always_comb begin
        fifo_data_in = '0;
        fifo_empty   = '1;
        for (int q = 0; q < NQ; q++) begin
            fifo_empty[q]             = (wr_ptr[q] == rd_ptr[q]);
            fifo_data_in[q*EW +: EW]  = mem[q][rd_ptr[q] % DEPTH];
        end
    end

    always @(posedge clk) begin
        #1;
        for (int q = 0; q < NQ; q++) begin
            if (pend[q]) rd_ptr[q] <= rd_ptr[q] + 1;
        end
    end

    // Each test pushes descriptors in exactly the round-robin order the
    // scheduler must issue them, so the expectation is queued with the entry.
    task automatic push(input int q, input logic [15:0] len);
        exp_t          e;
        logic [TW-1:0] t;
        t = {8'(q), 32'(wr_ptr[q]), 64'hDEAD_BEEF_0000_0000 + 64'(len)};
        mem[q][wr_ptr[q] % DEPTH] = {t, len};
        wr_ptr[q] = wr_ptr[q] + 1;
        e.qid   = 2'(q);
        e.len   = len;
        e.tuple = t;
        exp_q.push_back(e);
    endtask

    // Monitor sampling mid-cycle: pop legality, stall payload and accepted descriptors.
    always @(negedge clk) begin
        if (resetn) begin
            pend <= fifo_rd_en;
            if (fifo_rd_en != '0) begin
                check_eq("rd_en_onehot", 128'($onehot(fifo_rd_en)), 128'd1);
                check_eq("rd_en_nonempty", 128'(fifo_rd_en & fifo_empty), 128'd0);
                check_eq("rd_en_in_idle", 128'(sched_busy), 128'd0);
                for (int q = 0; q < NQ; q++) begin
                    if (fifo_rd_en[q]) pop_cnt[q] <= pop_cnt[q] + 1;
                end
            end
            if (sched_vld && !sched_ready && exp_q.size() != 0) begin
                check_eq("stall_payload", 128'({sched_qid, sched_len, sched_tuple}), 128'(exp_q[0]));
            end
            if (sched_vld && sched_ready) begin
                check_eq("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    check_eq("issue_qid", 128'(sched_qid), 128'(exp_q[0].qid));
                    check_eq("issue_len", 128'(sched_len), 128'(exp_q[0].len));
                    check_eq("issue_tuple", 128'(sched_tuple), 128'(exp_q[0].tuple));
                    exp_q.delete(0);
                end
                check_eq("pkt_count_pre", 128'(pkt_count), 128'(32'(acc_cnt - acc_base)));
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            pend <= '0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_vld(input logic lvl, input int budget, inout int n);
        int b;
        b = budget;
        while (sched_vld !== lvl && b > 0) begin
            step();
            n++;
            b--;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || sched_busy || !(&fifo_empty)) && i < budget) begin
            step();
            i++;
        end
        check_eq({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        sched_ready = 1'b1;
        cfg_enable  = 1'b1;
        step(2);
        check_eq("rst_vld", 128'(sched_vld), 128'd0);
        check_eq("rst_busy", 128'(sched_busy), 128'd0);
        check_eq("rst_pkt_count", 128'(pkt_count), 128'd0);
        check_eq("rst_rd_en", 128'(fifo_rd_en), 128'd0);
        check_eq("rst_payload", 128'({sched_qid, sched_len, sched_tuple}), 128'd0);
        acc_base = acc_cnt;
        for (int q = 0; q < NQ; q++) pop_base[q] = pop_cnt[q];
    endtask

    function automatic int pops(input int q);
        return pop_cnt[q] - pop_base[q];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;

        // Single entry on queue 2, unlimited rate: valid two edges after the pop.
        do_reset();
        cfg_rate       = 24'hFFFFFF;
        cfg_bucket_max = 24'hFFFFFF;
        push(2, 16'd64);
        step(1);
        check_eq("t1_no_pop_in_reset", 128'(fifo_rd_en), 128'd0);
        resetn = 1'b1;
        n = 0;
        wait_vld(1'b1, 20, n);
        check_eq("t1_latency", 128'(n), 128'd2);
        drain("t1", 50);
        check_eq("t1_pops_q2", 128'(pops(2)), 128'd1);
        check_eq("t1_pkt_count", 128'(pkt_count), 128'd1);

        // All queues loaded twice: strict 0,1,2,3,0,1,2,3 rotation.
        do_reset();
        for (int e = 0; e < 2; e++)
            for (int q = 0; q < NQ; q++) push(q, 16'(100 + 10*q + e));
        resetn = 1'b1;
        drain("t2", 200);
        for (int q = 0; q < NQ; q++) check_eq($sformatf("t2_pops_q%0d", q), 128'(pops(q)), 128'd2);
        check_eq("t2_pkt_count", 128'(pkt_count), 128'd8);

        // rate 8: 64 tokens are present in the cycle after edge 8, so valid
        // follows edge 9; tokens are then 8, the 32-byte follow-up (popped
        // after edge 10) sees 24, then 32, and goes valid after edge 13.
        do_reset();
        cfg_rate       = 24'd8;
        cfg_bucket_max = 24'd1500;
        push(0, 16'd64);
        push(1, 16'd32);
        resetn = 1'b1;
        n = 0;
        wait_vld(1'b1, 40, n);
        check_eq("t3_first_vld", 128'(n), 128'd9);
        wait_vld(1'b0, 5, n);
        wait_vld(1'b1, 40, n);
        check_eq("t3_second_vld", 128'(n), 128'd13);
        drain("t3", 50);

        // Backpressure: ten stalled cycles with another queue waiting.
        do_reset();
        cfg_rate       = 24'hFFFFFF;
        cfg_bucket_max = 24'hFFFFFF;
        sched_ready    = 1'b0;
        push(1, 16'd200);
        push(2, 16'd300);
        resetn = 1'b1;
        n = 0;
        wait_vld(1'b1, 20, n);
        check_eq("t4_latency", 128'(n), 128'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("t4_vld_held", 128'(sched_vld), 128'd1);
            check_eq("t4_count_held", 128'(pkt_count), 128'd0);
        end
        check_eq("t4_no_extra_pop", 128'(pops(2)), 128'd0);
        sched_ready = 1'b1;
        drain("t4", 50);
        check_eq("t4_pops_q2", 128'(pops(2)), 128'd1);

        // Oversized 2000-byte packet against a 1500 ceiling at rate 100:
        // full bucket after edge 15, valid after 16, tokens back to 100.
        // Next 300-byte packet sees 300 after edge 18 -> valid after 19;
        // a zero-length one then passes WAIT_TOKEN at once -> valid after 22.
        do_reset();
        cfg_rate       = 24'd100;
        cfg_bucket_max = 24'd1500;
        push(0, 16'd2000);
        push(1, 16'd300);
        push(2, 16'd0);
        resetn = 1'b1;
        n = 0;
        wait_vld(1'b1, 40, n);
        check_eq("t5_big_vld", 128'(n), 128'd16);
        wait_vld(1'b0, 5, n);
        wait_vld(1'b1, 40, n);
        check_eq("t5_after_drain_vld", 128'(n), 128'd19);
        wait_vld(1'b0, 5, n);
        wait_vld(1'b1, 40, n);
        check_eq("t5_zero_len_vld", 128'(n), 128'd22);
        drain("t5", 50);

        // Enable dropped while waiting for tokens: captured descriptor still
        // issues, no new pop until re-enabled, then rotation resumes at queue 1.
        do_reset();
        cfg_rate       = 24'd10;
        cfg_bucket_max = 24'd1500;
        push(0, 16'd100);
        push(1, 16'd10);
        push(2, 16'd10);
        resetn = 1'b1;
        step(1);
        cfg_enable = 1'b0;
        step(29);
        check_eq("t6_issued_while_off", 128'(pkt_count), 128'd1);
        check_eq("t6_idle_while_off", 128'(sched_busy), 128'd0);
        check_eq("t6_no_pop_q1", 128'(pops(1)), 128'd0);
        check_eq("t6_no_pop_q2", 128'(pops(2)), 128'd0);
        cfg_enable = 1'b1;
        drain("t6", 100);
        check_eq("t6_pkt_count", 128'(pkt_count), 128'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
